move_queue: RTL

MOVE_QUEUE -- requirements
Module: move_queue

---
 rtl/move_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/move_queue.sv
// -----------------------------------------------------------------------------
// move_queue
// Small show-ahead FIFO of frog moves decoded from raw keyboard codes. A key
// press is a cycle where the keycode changes to one of the recognised codes.
// The frog position stage pops one move per update with tick.
//
// Optional feature macro: MOVE_QUEUE_REPEAT_EN
//   When defined, a direction key held unchanged re-enqueues itself every
//   REPEAT_CYCLES cycles. When undefined, a held key gives exactly one press.
//
// Parameters
//   DEPTH          queue entries, power of two, 2..8
//   REPEAT_CYCLES  auto-repeat interval in Clk cycles (repeat build only)
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   keycode     in   16-bit raw key code, 16'h0000 = no key
//   tick        in   pop strobe, one Clk per frog update
//   hold        in   game halted: only start presses are accepted
//   flush       in   discard all pending moves and clear overflow
//   move_valid  out  head entry holds a move
//   move_dir    out  head move: 1 up, 2 down, 3 left, 4 right, 5 start, 0 none
//   count       out  occupied entries, 0..DEPTH
//   overflow    out  sticky: a press was dropped because the queue was full
// -----------------------------------------------------------------------------
module move_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [23:0] REPEAT_CYCLES = 24'd12_500_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        tick,
  input  logic        hold,
  input  logic        flush,
  output logic        move_valid,
  output logic [2:0]  move_dir,
  output logic [3:0]  count,
  output logic        overflow
);

  localparam int         PW         = $clog2(DEPTH);
  localparam logic [3:0] FULL_COUNT = 4'(DEPTH);
  localparam logic [2:0] DIR_NONE   = 3'd0;
  localparam logic [2:0] DIR_UP     = 3'd1;
  localparam logic [2:0] DIR_DOWN   = 3'd2;
  localparam logic [2:0] DIR_LEFT   = 3'd3;
  localparam logic [2:0] DIR_RIGHT  = 3'd4;
  localparam logic [2:0] DIR_START  = 3'd5;

  logic [15:0]   r_prev_key;
  logic [2:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_overflow;

  logic [2:0]    w_code;
  logic          w_key_changed;
  logic          w_press;
  logic          w_repeat;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;

  // Only exact 16-bit matches count; anything else decodes to "none".
  always_comb begin
    w_code = DIR_NONE;
    case (keycode)
      16'h001A: w_code = DIR_UP;
      16'h0016: w_code = DIR_DOWN;
      16'h0004: w_code = DIR_LEFT;
      16'h0007: w_code = DIR_RIGHT;
      16'h002C: w_code = DIR_START;
      default:  w_code = DIR_NONE;
    endcase
  end

  assign w_key_changed = (keycode != r_prev_key);
  assign w_press       = w_key_changed && (w_code != DIR_NONE);

`ifdef MOVE_QUEUE_REPEAT_EN
  logic [23:0] r_rep_cnt;
  logic        w_is_dir;

  assign w_is_dir = (w_code >= DIR_UP) && (w_code <= DIR_RIGHT);
  // The counter holds the number of held cycles since the last enqueue or
  // drop, minus one; reaching REPEAT_CYCLES-1 means the interval has elapsed.
  assign w_repeat = !w_key_changed && w_is_dir &&
                    (r_rep_cnt == REPEAT_CYCLES - 24'd1);

  always_ff @(posedge Clk) begin
    if (Reset || flush || w_key_changed || !w_is_dir || w_repeat) begin
      r_rep_cnt <= 24'd0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 24'd1;
    end
  end
`else
  logic w_unused_repeat;
  assign w_repeat        = 1'b0;
  assign w_unused_repeat = ^REPEAT_CYCLES;
`endif

  // While halted, direction presses (including repeats) vanish silently.
  assign w_push  = (w_press || w_repeat) && (!hold || (w_code == DIR_START));
  assign w_empty = (r_count == 4'd0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = tick && !w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev_key <= 16'h0000;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      // prev_key tracks the input even during flush/hold so a held key is
      // never seen as a fresh press afterwards.
      r_prev_key <= keycode;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= 4'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_write, w_pop})
          2'b10:   r_count <= r_count + 4'd1;
          2'b01:   r_count <= r_count - 4'd1;
          default: r_count <= r_count;
        endcase
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge Clk) begin
    if (!Reset && !flush && w_write) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  assign move_valid = !w_empty;
  assign move_dir   = w_empty ? DIR_NONE : r_mem[r_rd_ptr];
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule
